johnson_decoder: RTL and testbench

//   Receiving end of the 8-bit Johnson counter interface. Samples a Johnson-coded

---
 rtl/johnson_decoder.sv | 131 +++++++++++++
 tb/tb_johnson_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// Receive-side decoder for an 8-bit Johnson counter link: decodes each strobed word,
// tracks sequence continuity with a lock FSM and counts errors seen while locked.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SEARCH  | no legal reference sample yet; waiting for any legal code
// CONFIRM | have a reference; counting consecutive correct successors
// LOCKED  | sequence confirmed; deviations pulse seq_err and bump err_count

module johnson_decoder #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8,
    localparam int IDX_W   = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             valid_in,
    output logic [IDX_W-1:0] idx,
    output logic             code_ok,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int MC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2*WIDTH - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          state;
    logic [MC_W-1:0] match_cnt;

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] mag_inc;
    logic [IDX_W-1:0] ones;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] next_idx;
    logic             dec_legal;
    logic             succ;
    logic             err_sat;

    // Folding the upper half onto the lower half means every legal code becomes
    // 2^k-1, which is legal exactly when adding one clears every set bit.
    always_comb begin
        mag       = q_in[WIDTH-1] ? ~q_in : q_in;
        mag_inc   = mag + WIDTH'(1);
        dec_legal = ((mag & mag_inc) == '0);
        ones      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + IDX_W'(mag[i]);
        end
        dec_idx   = q_in[WIDTH-1] ? (IDX_W'(WIDTH) + ones) : ones;
        next_idx  = (idx == IDX_LAST) ? '0 : (idx + IDX_W'(1));
        succ      = dec_legal && (dec_idx == next_idx);
        err_sat   = (err_count == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            match_cnt <= '0;
            idx       <= '0;
            code_ok   <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            seq_err <= 1'b0;
            if (valid_in) begin
                code_ok <= dec_legal;
                if (dec_legal) begin
                    idx <= dec_idx;
                end
                case (state)
                    SEARCH: begin
                        if (dec_legal) begin
                            state     <= CONFIRM;
                            match_cnt <= '0;
                        end
                        locked <= 1'b0;
                    end
                    CONFIRM: begin
                        if (succ) begin
                            if (match_cnt == LOCK_LAST) begin
                                state     <= LOCKED;
                                match_cnt <= '0;
                                locked    <= 1'b1;
                            end else begin
                                match_cnt <= match_cnt + MC_W'(1);
                                locked    <= 1'b0;
                            end
                        end else if (dec_legal) begin
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end else begin
                            state     <= SEARCH;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (succ) begin
                            locked <= 1'b1;
                        end else begin
                            seq_err   <= 1'b1;
                            if (!err_sat) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            state     <= dec_legal ? CONFIRM : SEARCH;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= SEARCH;
                        match_cnt <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed, table-driven bench for johnson_decoder; a second instance with a 2-bit
// error counter runs the same stimulus to exercise saturation.

module tb_johnson_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] q_in;
    logic       valid_in;

    logic [3:0] idx,  idx2;
    logic       code_ok, code_ok2;
    logic       seq_err, seq_err2;
    logic       locked,  locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int n_tests = 0;
    int n_fail  = 0;

    johnson_decoder #(.WIDTH(8), .LOCK_CNT(2), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .valid_in(valid_in),
        .idx(idx), .code_ok(code_ok), .seq_err(seq_err), .locked(locked),
        .err_count(err_count)
    );

    johnson_decoder #(.WIDTH(8), .LOCK_CNT(2), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .q_in(q_in), .valid_in(valid_in),
        .idx(idx2), .code_ok(code_ok2), .seq_err(seq_err2), .locked(locked2),
        .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] q;
        int         e_idx;
        logic       e_ok;
        logic       e_se;
        logic       e_lk;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] q, int e_idx, logic e_ok,
                                logic e_se, logic e_lk, int e_cnt);
        vec_t r;
        r.v = v; r.q = q; r.e_idx = e_idx; r.e_ok = e_ok;
        r.e_se = e_se; r.e_lk = e_lk; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int step, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
        end
    endtask

    task automatic chk_all(input int step, input int e_idx, input logic e_ok,
                           input logic e_se, input logic e_lk, input int e_cnt);
        int e_cnt2;
        e_cnt2 = (e_cnt > 3) ? 3 : e_cnt;
        chk("idx",        step, int'(idx),        e_idx);
        chk("code_ok",    step, int'(code_ok),    int'(e_ok));
        chk("seq_err",    step, int'(seq_err),    int'(e_se));
        chk("locked",     step, int'(locked),     int'(e_lk));
        chk("err_count",  step, int'(err_count),  e_cnt);
        chk("err_count2", step, int'(err_count2), e_cnt2);
    endtask

    initial begin
        // test 1: quiet after reset, q_in must be ignored while valid_in is low
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b0, 8'h01, 0, 0, 0, 0, 0));
        // test 2: acquire lock
        vecs.push_back(mk(1'b1, 8'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1'b1, 8'h01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1'b1, 8'h03, 2, 1, 0, 1, 0));
        // test 3: full cycle with wrap 15 -> 0, back to idx 2
        vecs.push_back(mk(1'b1, 8'h07,  3, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'h0F,  4, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'h1F,  5, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'h3F,  6, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'h7F,  7, 1, 0, 1, 0));
        vecs.push_back(mk(1'b0, 8'h55,  7, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'hFF,  8, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'hFE,  9, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'hFC, 10, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'hF8, 11, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'hF0, 12, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'hE0, 13, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'hC0, 14, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'h80, 15, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'h00,  0, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'h01,  1, 1, 0, 1, 0));
        vecs.push_back(mk(1'b1, 8'h03,  2, 1, 0, 1, 0));
        // test 4: illegal code while locked, pulse clears when valid_in drops, relock
        vecs.push_back(mk(1'b1, 8'h05, 2, 0, 1, 0, 1));
        vecs.push_back(mk(1'b0, 8'h05, 2, 0, 0, 0, 1));
        vecs.push_back(mk(1'b1, 8'h00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1'b1, 8'h01, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1'b1, 8'h03, 2, 1, 0, 1, 1));
        // test 5: skip while locked, then reconfirm from the new reference
        vecs.push_back(mk(1'b1, 8'h0F, 4, 1, 1, 0, 2));
        vecs.push_back(mk(1'b1, 8'h1F, 5, 1, 0, 0, 2));
        vecs.push_back(mk(1'b1, 8'h3F, 6, 1, 0, 1, 2));
        // jump to 0 while locked; errors in CONFIRM/SEARCH stay silent
        vecs.push_back(mk(1'b1, 8'h00, 0, 1, 1, 0, 3));
        vecs.push_back(mk(1'b1, 8'h00, 0, 1, 0, 0, 3));
        vecs.push_back(mk(1'b1, 8'h55, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1'b1, 8'h00, 0, 1, 0, 0, 3));
        vecs.push_back(mk(1'b1, 8'h01, 1, 1, 0, 0, 3));
        vecs.push_back(mk(1'b1, 8'h03, 2, 1, 0, 1, 3));
        // repeat while locked (2-bit counter saturates from here on)
        vecs.push_back(mk(1'b1, 8'h03, 2, 1, 1, 0, 4));
        vecs.push_back(mk(1'b1, 8'h07, 3, 1, 0, 0, 4));
        vecs.push_back(mk(1'b1, 8'h0F, 4, 1, 0, 1, 4));
        // jump into upper half, relock, then an illegal upper-half code
        vecs.push_back(mk(1'b1, 8'hFF,  8, 1, 1, 0, 5));
        vecs.push_back(mk(1'b1, 8'hFE,  9, 1, 0, 0, 5));
        vecs.push_back(mk(1'b1, 8'hFC, 10, 1, 0, 1, 5));
        vecs.push_back(mk(1'b1, 8'h81, 10, 0, 1, 0, 6));
        vecs.push_back(mk(1'b0, 8'h00, 10, 0, 0, 0, 6));

        reset    = 1'b1;
        valid_in = 1'b0;
        q_in     = 8'h00;
        repeat (2) @(negedge clk);
        chk_all(-1, 0, 0, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            valid_in = vecs[i].v;
            q_in     = vecs[i].q;
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].e_idx, vecs[i].e_ok, vecs[i].e_se,
                    vecs[i].e_lk, vecs[i].e_cnt);
        end

        // test 6 tail: relock, then reset between edges must clear at once
        @(negedge clk); valid_in = 1'b1; q_in = 8'h00;
        @(negedge clk); q_in = 8'h01;
        @(negedge clk); q_in = 8'h03;
        @(negedge clk); valid_in = 1'b0;
        chk("relock", 100, int'(locked), 1);
        chk("relock2", 100, int'(locked2), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all(101, 0, 0, 0, 0, 0);
        chk("locked2_rst", 101, int'(locked2), 0);
        chk("idx2_rst",    101, int'(idx2), 0);
        chk("ok2_rst",     101, int'(code_ok2), 0);
        @(negedge clk);
        reset = 1'b0;
        // after reset a fresh lock needs the full confirmation again
        valid_in = 1'b1; q_in = 8'h07;
        @(posedge clk); #1;
        chk_all(102, 3, 1, 0, 0, 0);
        @(negedge clk); q_in = 8'h0F;
        @(posedge clk); #1;
        chk_all(103, 4, 1, 0, 0, 0);
        @(negedge clk); q_in = 8'h1F;
        @(posedge clk); #1;
        chk_all(104, 5, 1, 0, 1, 0);
        @(negedge clk); valid_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
